// File: rtl/msg_schedule_stream.sv
// -----------------------------------------------------------------------------
// msg_schedule_stream
//   Streaming SHA-2 message-schedule expander. Loads one padded 16-word block
//   and emits W[0..ROUNDS-1] one word per handshake from a rolling 16-word
//   window. Each handshake retires win[0] and appends the next expanded word.
//   WORD_W=32 selects the SHA-256 sigma set, WORD_W=64 the SHA-512 set.
//   Legal ROUNDS is 17..255: 64 for SHA-256, 80 for SHA-512.
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-high; aborts any block in flight
//   start     in   load block_in; ignored while busy
//   block_in  in   16*WORD_W padded block, W[0] in the most significant word
//   busy      out  block in progress (cycle after acceptance .. final handshake)
//   w_valid   out  w_out / w_index hold a schedule word
//   w_ready   in   consumer accepts the word (transfer = w_valid & w_ready)
//   w_out     out  schedule word W[w_index], zero when not valid
//   w_index   out  round index 0..ROUNDS-1, zero when not valid
//   done      out  one-cycle pulse after W[ROUNDS-1] transfers
// -----------------------------------------------------------------------------
module msg_schedule_stream #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [16*WORD_W-1:0]  block_in,
  output logic                  busy,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [WORD_W-1:0]     w_out,
  output logic [7:0]            w_index,
  output logic                  done
);

  localparam logic [7:0] LAST_IDX = 8'(ROUNDS - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WORD_W-1:0] win [16];
  logic [7:0]        t;
  logic              transfer;
  logic              last;
  logic [WORD_W-1:0] nw;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                              input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    if (WORD_W == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    else              return rotr(x, 1) ^ rotr(x, 8)  ^ (x >> 7);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    if (WORD_W == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    else              return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  assign w_valid  = (state == RUN);
  assign busy     = w_valid;
  assign transfer = w_valid & w_ready;
  assign last     = (t == LAST_IDX);

  // Outputs come straight from registers; w_ready only steers the next state,
  // so there is no combinational path from w_ready to w_out.
  assign w_out   = w_valid ? win[0] : '0;
  assign w_index = w_valid ? t : '0;

  // Single 4-operand adder fed only by window registers; carries out of the
  // word are discarded. Words beyond ROUNDS-1 land in the window unused.
  assign nw = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  // NOTE: every output of a combinational block gets a default before the
  // case so that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start)           state_next = RUN;
      RUN:  if (transfer && last) state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge (the shift relies on it).
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      t     <= '0;
      done  <= 1'b0;
      // NOTE: the window is deliberately reset so no word of an aborted
      // block can survive; it is only 16 registers, not a RAM.
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      state <= state_next;
      done  <= transfer && last;
      if (state == IDLE && start) begin
        for (int i = 0; i < 16; i++)
          win[i] <= block_in[(16-i)*WORD_W-1 -: WORD_W];
        t <= '0;
      end else if (transfer && !last) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= nw;
        t       <= t + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_msg_schedule_stream.sv
// -----------------------------------------------------------------------------
// tb_msg_schedule_stream
//   Bench for msg_schedule_stream with one SHA-256 instance and one SHA-512
//   instance. Stimulus pushes the full expected schedule (computed from the
//   SHA-2 recurrence over a plain array) into a per-instance queue when a
//   block is started; a negedge monitor pops and compares on every handshake,
//   checks hold-stability under back-pressure and the done pulse position.
// -----------------------------------------------------------------------------
module tb_msg_schedule_stream;

  typedef struct {
    logic [63:0] w;
    logic [7:0]  idx;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  int            cyc = 0;

  logic          start32, w_ready32, busy32, w_valid32, done32;
  logic [511:0]  block32;
  logic [31:0]   w_out32;
  logic [7:0]    w_index32;

  logic          start64, w_ready64, busy64, w_valid64, done64;
  logic [1023:0] block64;
  logic [63:0]   w_out64;
  logic [7:0]    w_index64;

  int            n_total = 0;
  int            n_pass  = 0;

  exp_t          sb0[$];
  exp_t          sb1[$];
  logic [63:0]   blk [16];
  bit            t1_on = 1'b0;
  int            xfer_cnt [2];
  int            last_xfer [2];
  bit            hold [2];
  logic [63:0]   hold_w [2];
  logic [7:0]    hold_i [2];

  logic          mv [2], mr [2], md [2];
  logic [63:0]   mw [2];
  logic [7:0]    mi [2];

  msg_schedule_stream #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .block_in(block32),
    .busy(busy32), .w_valid(w_valid32), .w_ready(w_ready32),
    .w_out(w_out32), .w_index(w_index32), .done(done32)
  );

  msg_schedule_stream #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clock(clock), .reset(reset), .start(start64), .block_in(block64),
    .busy(busy64), .w_valid(w_valid64), .w_ready(w_ready64),
    .w_out(w_out64), .w_index(w_index64), .done(done64)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always_comb begin
    mv[0] = w_valid32; mr[0] = w_ready32; md[0] = done32;
    mw[0] = {32'b0, w_out32}; mi[0] = w_index32;
    mv[1] = w_valid64; mr[1] = w_ready64; md[1] = done64;
    mw[1] = w_out64; mi[1] = w_index64;
  end

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] mask_of(input int ww);
    return (ww == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] rr(input logic [63:0] x, input int n, input int ww);
    return ((x >> n) | (x << (ww - n))) & mask_of(ww);
  endfunction

  function automatic logic [63:0] ms0(input logic [63:0] x, input int ww);
    if (ww == 32) return rr(x, 7, 32) ^ rr(x, 18, 32) ^ (x >> 3);
    return rr(x, 1, 64) ^ rr(x, 8, 64) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] ms1(input logic [63:0] x, input int ww);
    if (ww == 32) return rr(x, 17, 32) ^ rr(x, 19, 32) ^ (x >> 10);
    return rr(x, 19, 64) ^ rr(x, 61, 64) ^ (x >> 6);
  endfunction

  task automatic push_expected(input int k);
    int          ww = (k == 0) ? 32 : 64;
    int          rn = (k == 0) ? 64 : 80;
    logic [63:0] m  = mask_of(ww);
    logic [63:0] w [80];
    exp_t        e;
    for (int i = 0; i < 16; i++) w[i] = blk[i] & m;
    for (int i = 16; i < rn; i++)
      w[i] = (ms1(w[i-2], ww) + w[i-7] + ms0(w[i-15], ww) + w[i-16]) & m;
    for (int i = 0; i < rn; i++) begin
      e.w = w[i]; e.idx = 8'(i);
      if (k == 0) sb0.push_back(e); else sb1.push_back(e);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      bit   got;
      if (reset) begin
        hold[k] = 1'b0;
        continue;
      end
      if (hold[k])
        check(mv[k] && mw[k] == hold_w[k] && mi[k] == hold_i[k], "hold_stable",
              {mi[k], mw[k][55:0]}, {hold_i[k], hold_w[k][55:0]});
      if (mv[k] && mr[k]) begin
        got = 1'b0;
        if (k == 0 && sb0.size() > 0) begin e = sb0.pop_front(); got = 1'b1; end
        if (k == 1 && sb1.size() > 0) begin e = sb1.pop_front(); got = 1'b1; end
        if (!got) begin
          check(1'b0, "unexpected_word", mw[k], 64'h0);
        end else begin
          check(mi[k] == e.idx, "w_index", 64'(mi[k]), 64'(e.idx));
          check(mw[k] == e.w, "w_out", mw[k], e.w);
          xfer_cnt[k]++;
          if (e.idx == ((k == 0) ? 8'd63 : 8'd79)) last_xfer[k] = cyc;
        end
      end
      if (md[k] || cyc == last_xfer[k] + 1)
        check(md[k] == (cyc == last_xfer[k] + 1), "done_pulse",
              64'(md[k]), 64'(cyc == last_xfer[k] + 1));
      if (k == 0 && t1_on && mv[0]) begin
        case (mi[0])
          8'd0:  check(mw[0] == 64'h61626380, "t1_W0",  mw[0], 64'h61626380);
          8'd15: check(mw[0] == 64'h00000018, "t1_W15", mw[0], 64'h00000018);
          8'd16: check(mw[0] == 64'h61626380, "t1_W16", mw[0], 64'h61626380);
          8'd17: check(mw[0] == 64'h000F0000, "t1_W17", mw[0], 64'h000F0000);
          8'd18: check(mw[0] == 64'h7DA86405, "t1_W18", mw[0], 64'h7DA86405);
          default: ;
        endcase
      end
      hold[k]   = mv[k] && !mr[k];
      hold_w[k] = mw[k];
      hold_i[k] = mi[k];
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_block(input int k);
    for (int i = 0; i < 16; i++) begin
      if (k == 0) block32[(15-i)*32 +: 32] = blk[i][31:0];
      else        block64[(15-i)*64 +: 64] = blk[i];
    end
  endtask

  task automatic random_block();
    for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom};
  endtask

  task automatic abc_block(input int k);
    for (int i = 0; i < 16; i++) blk[i] = 64'h0;
    blk[0]  = (k == 0) ? 64'h0000_0000_6162_6380 : 64'h6162_6380_0000_0000;
    blk[15] = 64'h18;
  endtask

  // Starts the current blk on instance k; a = first cycle with w_valid.
  task automatic issue(input int k, output int a);
    drive_block(k);
    push_expected(k);
    if (k == 0) start32 = 1'b1; else start64 = 1'b1;
    tick();
    start32 = 1'b0; start64 = 1'b0;
    a = cyc;
  endtask

  task automatic wait_done(input int k, output int at);
    int n = 0;
    while (!((k == 0) ? done32 : done64) && n < 3000) begin
      tick();
      n++;
    end
    at = cyc;
    check(n < 3000, "done_timeout", 64'(n), 64'd3000);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int a, at;
    reset = 1'b1;
    start32 = 1'b0; start64 = 1'b0;
    w_ready32 = 1'b1; w_ready64 = 1'b1;
    block32 = '0; block64 = '0;
    for (int k = 0; k < 2; k++) begin
      xfer_cnt[k] = 0; last_xfer[k] = -100; hold[k] = 1'b0;
    end
    repeat (3) tick();
    reset = 1'b0;
    check({busy32, w_valid32, done32} == 3'b0, "reset_flags32", 64'({busy32, w_valid32, done32}), 64'h0);
    check(w_out32 == 32'h0 && w_index32 == 8'h0, "reset_out32", 64'(w_out32), 64'h0);
    check({busy64, w_valid64, done64} == 3'b0, "reset_flags64", 64'({busy64, w_valid64, done64}), 64'h0);
    check(w_out64 == 64'h0 && w_index64 == 8'h0, "reset_out64", w_out64, 64'h0);
    repeat (2) tick();

    // T1: SHA-256 "abc", ready held high; block_in scrambled after acceptance
    t1_on = 1'b1;
    abc_block(0);
    issue(0, a);
    check(busy32 && w_valid32 && w_index32 == 8'd0, "t1_first_valid",
          64'({busy32, w_valid32, w_index32}), 64'h300);
    random_block(); drive_block(0);
    wait_done(0, at);
    check(at == a + 64, "t1_done_cycle", 64'(at), 64'(a + 64));
    check(!busy32 && !w_valid32, "t1_idle_at_done", 64'({busy32, w_valid32}), 64'h0);
    t1_on = 1'b0;
    check(sb0.size() == 0, "t1_drained", 64'(sb0.size()), 64'h0);
    repeat (3) tick();

    // T2: same block, random back-pressure
    abc_block(0);
    xfer_cnt[0] = 0;
    issue(0, a);
    begin
      int n = 0;
      while (!done32 && n < 3000) begin
        w_ready32 = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
    end
    w_ready32 = 1'b1;
    check(xfer_cnt[0] == 64, "t2_transfers", 64'(xfer_cnt[0]), 64'd64);
    check(sb0.size() == 0, "t2_drained", 64'(sb0.size()), 64'h0);
    repeat (2) tick();

    // T3: start pulses at t=5 and t=63 ignored; start in the done cycle accepted
    random_block();
    issue(0, a);
    while (cyc < a + 64) begin
      start32 = (cyc == a + 5) || (cyc == a + 63);
      if (start32) begin random_block(); drive_block(0); end
      tick();
    end
    start32 = 1'b0;
    check(done32 == 1'b1, "t3_done", 64'(done32), 64'h1);
    random_block();
    issue(0, a);
    check(w_valid32 && w_index32 == 8'd0, "t3_restart", 64'({w_valid32, w_index32}), 64'h100);
    wait_done(0, at);
    check(at == a + 64, "t3_done_cycle", 64'(at), 64'(a + 64));
    check(sb0.size() == 0, "t3_drained", 64'(sb0.size()), 64'h0);
    repeat (2) tick();

    // T4: reset while W[30] is presented, then a clean block
    random_block();
    issue(0, a);
    while (cyc < a + 30) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb0.delete();
    check({busy32, w_valid32, done32} == 3'b0, "t4_flags", 64'({busy32, w_valid32, done32}), 64'h0);
    check(w_index32 == 8'd0 && w_out32 == 32'd0, "t4_out", {24'h0, w_index32, w_out32}, 64'h0);
    tick();
    random_block();
    issue(0, a);
    wait_done(0, at);
    check(sb0.size() == 0, "t4_drained", 64'(sb0.size()), 64'h0);
    repeat (2) tick();

    // T5: all-ones block exercises adder wrap
    for (int i = 0; i < 16; i++) blk[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    issue(0, a);
    wait_done(0, at);
    check(sb0.size() == 0, "t5_drained", 64'(sb0.size()), 64'h0);
    repeat (2) tick();

    // T6: SHA-512 "abc"
    abc_block(1);
    issue(1, a);
    check(w_valid64 && w_out64 == 64'h6162638000000000, "t6_W0", w_out64, 64'h6162638000000000);
    wait_done(1, at);
    check(at == a + 80, "t6_done_cycle", 64'(at), 64'(a + 80));
    check(sb1.size() == 0, "t6_drained", 64'(sb1.size()), 64'h0);

    // a random SHA-512 block with back-pressure
    random_block();
    issue(1, a);
    begin
      int n = 0;
      while (!done64 && n < 3000) begin
        w_ready64 = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
    end
    w_ready64 = 1'b1;
    check(sb1.size() == 0, "t6_random_drained", 64'(sb1.size()), 64'h0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
